key_matrix_scanner: RTL and testbench
=====================================

# key_matrix_scanner

Scans an N×N key/switch matrix by strobing columns and sensing rows, which is the input counterpart of the LED array driver's row/column multiplexing. It debounces each key and keeps a flattened `keys` bitmap indexed like the game grid (N*y + x). It also reports every debounced press or release as an event over a valid/ready handshake. It sits beside the LED driver in `main` and feeds user-drawn initial conditions and controls into the game.

## Interface

**Parameters**
- `N`, default 5: matrix is N columns × N rows; must be ≥ 2.
- `SETTLE_CYCLES`, default 16: clocks a column is driven before the rows are sampled; must be ≥ 1.
- `DEBOUNCE_SCANS`, default 4: number of consecutive differing samples needed to flip a key; must be ≥ 1.

**Ports**
- `clk` input 1: system clock (12 MHz).
- `rst` input 1: asynchronous reset, active-high.
- `ena` input 1: scanning enable.
- `rows_in` input N: row sense; 1 = key pressed in the driven column.
- `cols_out` output N: one-hot, active-high column drive; all zero when not driving.
- `keys` output N*N: debounced state; bit N*y+x is the key at column x, row y.
- `event_valid` output 1: a press/release event is offered.
- `event_ready` input 1: the consumer accepts the event.
- `event_index` output $clog2(N*N): key index N*y+x of the event.
- `event_pressed` output 1: 1 = press, 0 = release.
- `frame_done` output 1: one-cycle pulse when column N-1 completes and x wraps to 0.

## Operation

- **Reset:** all of the following are 0: `cols_out`, `keys`, all debounce counters, the pending mask, `event_valid`, `event_index`, `event_pressed`, `frame_done`, x, and the settle counter. State is IDLE.
- **FSM states:**
  - **IDLE:** `cols_out` = 0. Goes to DRIVE when `ena` = 1.
  - **DRIVE:** `cols_out` = 1<<x. The settle counter counts 0 to SETTLE_CYCLES-1, then the FSM goes to SAMPLE.
  - **SAMPLE:** one cycle, `cols_out` still driven.
    - For each row y, with k = N*y+x, compare the sample s = `rows_in`[y] (after the optional synchronizer) with `keys`[k].
    - If s equals `keys`[k], the counter for k clears.
    - Otherwise the counter increments. When it reaches DEBOUNCE_SCANS, `keys`[k] toggles, the counter clears, and pending[y] is set.
    - Next state is EMIT if any pending bit is set, else NEXT.
  - **EMIT:** `cols_out` is held. The lowest set pending bit y is presented: `event_index` = N*y+x and `event_pressed` = `keys`[k].
    - On `event_valid` && `event_ready`, pending[y] clears.
    - When pending becomes empty, the FSM goes to NEXT.
  - **NEXT:** `cols_out` = 0 for one cycle (break-before-make). x = (x == N-1) ? 0 : x+1, and `frame_done` pulses on the wrap. The FSM then goes to DRIVE if `ena` = 1, else IDLE.
- **`ena` deasserted mid-scan:** the current column completes, including all pending events, then the FSM goes to IDLE. x is retained.
- **Counter widths:**
  - Debounce counters are $clog2(DEBOUNCE_SCANS+1) bits and never wrap.
  - x is $clog2(N) bits.
  - Settle counter is $clog2(SETTLE_CYCLES) bits, minimum 1.
- **Debounce scope:** only keys in column x are updated in a given SAMPLE. Other columns hold their counters.

## Timing

- **Scan period:** one column takes SETTLE_CYCLES + 2 clocks (DRIVE + SAMPLE + NEXT) when nothing is pending. One frame is N times that.
- **SAMPLE to outputs:** `keys` updates on the clock edge ending SAMPLE. `event_valid` rises in the first EMIT cycle, the cycle after SAMPLE.
- **Event latency:** at least 1 cycle per event. Back-to-back events are possible with `event_ready` held high, one per clock.
- **Handshake:**
  - `event_index` and `event_pressed` are stable while `event_valid` && !`event_ready`.
  - `event_valid` never drops without acceptance, except on reset.
  - Scanning stalls indefinitely while the consumer withholds ready.
- **Asynchronous reset:** `rst` clears all state immediately, including mid-EMIT with `event_valid` high. The pending event is discarded.
- **First drive after reset:** with `ena` = 1, `cols_out` = 5'b00001 (N=5) appears on the first clock after `rst` falls.

## Configuration

- `KEY_SCAN_SYNC_EN`
  - **Defined:** `rows_in` passes through a 2-flop synchronizer, reset to 0, before sampling. This adds 2 cycles, so SETTLE_CYCLES must be ≥ 3 to sample data belonging to the driven column.
  - **Undefined:** `rows_in` is sampled directly in SAMPLE. This is for simulation and for synchronous stimulus only.

## Test plan

- **Reset:** assert `rst` mid-DRIVE → `cols_out` = 0, `keys` = 0, `event_valid` = 0, `frame_done` = 0 within the same cycle. After release with `ena` = 1, `cols_out` = 5'b00001.
- **Single press** (N=5, SETTLE=4, DEBOUNCE=2, sync off): hold `rows_in`[2] = 1 whenever col 3 is driven → after the 2nd col-3 SAMPLE, `keys`[13] = 1 and one event with index 13, pressed = 1.
- **Bounce rejection:** row 2 is high for only one col-3 scan, then low → no event, `keys`[13] stays 0, and the counter for key 13 returns to 0.
- **Same-column pair with back-pressure:** rows 0 and 4 pressed on col 1, `event_ready` low for 10 cycles → index 1 is held stable for 10 cycles, then index 21 follows. `cols_out` = 5'b00010 throughout and x does not advance.
- **Release:** after the single-press case, drop row 2 → after 2 col-3 scans, `keys`[13] = 0 and one event with index 13, pressed = 0.
- **Frame and enable:** idle matrix → `frame_done` pulses every 5×6 = 30 cycles. Deassert `ena` during col 2 DRIVE → col 2 completes, then `cols_out` = 0 and no further `frame_done`.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes the columns of an N x N key matrix one at a
// time, senses the rows, debounces every key and keeps a flattened bitmap
// (bit N*y+x = column x, row y). Each debounced press or release is offered
// as an event over a valid/ready handshake; scanning waits for the consumer.
// Optional build macro KEY_SCAN_SYNC_EN: when defined, rows_in passes through
// a 2-flop synchronizer before sampling (SETTLE_CYCLES must then be >= 3).
module key_matrix_scanner #(
  parameter int N              = 5,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [N-1:0]           rows_in,
  output logic [N-1:0]           cols_out,
  output logic [N*N-1:0]         keys,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [$clog2(N*N)-1:0] event_index,
  output logic                   event_pressed,
  output logic                   frame_done
);

  localparam int XW = $clog2(N);
  localparam int IW = $clog2(N*N);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [XW-1:0] X_LAST      = XW'(N - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_SCANS);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    NEXT
  } state_t;

  state_t state, state_next;

  logic [XW-1:0] x;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] deb_cnt [N*N];
  logic [N-1:0]  pending;
  logic [N-1:0]  row_sample;

  logic [IW-1:0] key_idx [N];
  logic [CW-1:0] cnt_inc [N];
  logic [N-1:0]  row_differs;
  logic [N-1:0]  row_toggles;
  logic [XW-1:0] sel_row;
  logic [N-1:0]  sel_onehot;
  logic [N-1:0]  pending_acked;

`ifdef KEY_SCAN_SYNC_EN
  logic [N-1:0] rows_meta;
  logic [N-1:0] rows_sync;

  // Two-flop synchronizer so asynchronous switch contacts cannot go metastable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= rows_in;
      rows_sync <= rows_meta;
    end
  end

  assign row_sample = rows_sync;
`else
  assign row_sample = rows_in;
`endif

  // Per-row view of the keys in the current column: index, mismatch, and whether this scan flips it
  always_comb begin
    for (int y = 0; y < N; y++) begin
      key_idx[y]     = IW'(N * y) + IW'(x);
      row_differs[y] = (row_sample[y] != keys[key_idx[y]]);
      cnt_inc[y]     = deb_cnt[key_idx[y]] + CW'(1);
      row_toggles[y] = row_differs[y] && (cnt_inc[y] == DEB_LIMIT);
    end
  end

  // Pick the lowest pending row; that is the event currently offered
  always_comb begin
    sel_row = '0;
    for (int y = N - 1; y >= 0; y--) begin
      if (pending[y]) sel_row = XW'(y);
    end
    sel_onehot    = N'(1) << sel_row;
    pending_acked = pending & ~sel_onehot;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a started column always runs to completion regardless of ena
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ena) state_next = DRIVE;
      DRIVE:   if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = (|row_toggles) ? EMIT : NEXT;
      EMIT:    if (event_ready && (pending_acked == '0)) state_next = NEXT;
      NEXT:    state_next = ena ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; column drive is dropped in NEXT for break-before-make
  always_comb begin
    cols_out      = '0;
    event_valid   = 1'b0;
    event_index   = '0;
    event_pressed = 1'b0;
    frame_done    = 1'b0;
    case (state)
      DRIVE, SAMPLE: cols_out = N'(1) << x;
      EMIT: begin
        cols_out      = N'(1) << x;
        event_valid   = 1'b1;
        event_index   = key_idx[sel_row];
        event_pressed = keys[key_idx[sel_row]];
      end
      NEXT:    frame_done = (x == X_LAST);
      default: ;
    endcase
  end

  // Scan datapath: settle timing, debounce of the driven column, event bookkeeping, column advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      x          <= '0;
      pending    <= '0;
      keys       <= '0;
      for (int k = 0; k < N * N; k++) deb_cnt[k] <= '0;
    end else begin
      case (state)
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
          else                           settle_cnt <= settle_cnt + SW'(1);
        end
        SAMPLE: begin
          for (int y = 0; y < N; y++) begin
            if (!row_differs[y]) begin
              deb_cnt[key_idx[y]] <= '0;
            end else if (row_toggles[y]) begin
              keys[key_idx[y]]    <= ~keys[key_idx[y]];
              deb_cnt[key_idx[y]] <= '0;
              pending[y]          <= 1'b1;
            end else begin
              deb_cnt[key_idx[y]] <= cnt_inc[y];
            end
          end
        end
        EMIT: begin
          if (event_ready) pending <= pending_acked;
        end
        NEXT: begin
          x <= (x == X_LAST) ? '0 : x + XW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed bench for key_matrix_scanner with N=5,
// SETTLE_CYCLES=4, DEBOUNCE_SCANS=2 (one column = 6 clocks, one frame = 30).
// A behavioural key matrix drives rows_in from cols_out and a pressed-key map.
module tb_key_matrix_scanner;

  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           ena;
  logic           event_ready;
  logic [N-1:0]   rows_in;
  logic [N-1:0]   cols_out;
  logic [N*N-1:0] keys;
  logic           event_valid;
  logic [4:0]     event_index;
  logic           event_pressed;
  logic           frame_done;

  logic [N*N-1:0] mat;

  int tests_run    = 0;
  int tests_failed = 0;

  int         ev_count = 0;
  logic [4:0] last_idx = '0;
  logic       last_pressed = 1'b0;

  key_matrix_scanner #(
    .N              (N),
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .rows_in       (rows_in),
    .cols_out      (cols_out),
    .keys          (keys),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_index   (event_index),
    .event_pressed (event_pressed),
    .frame_done    (frame_done)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key matrix model: a row reads 1 when a pressed key sits in a driven column
  always_comb begin
    rows_in = '0;
    for (int y = 0; y < N; y++) rows_in[y] = |(cols_out & mat[N*y +: N]);
  end

  // Record every accepted event
  always @(posedge clk) begin
    if (event_valid && event_ready) begin
      ev_count     <= ev_count + 1;
      last_idx     <= event_index;
      last_pressed <= event_pressed;
    end
  end

  task automatic applyStimulus(input logic e, input logic r, input logic [N*N-1:0] m);
    ena         = e;
    event_ready = r;
    mat         = m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Count negedges until frame_done is seen, bounded
  task automatic waitFrame(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  // Wait for a given column drive, bounded
  task automatic waitCols(input string tag, input logic [N-1:0] want);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cols_out == want) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  // Wait for event_valid, bounded
  task automatic waitValid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (event_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  // Directed sequence
  initial begin
    int   n;
    int   base;
    logic stable;
    logic quiet;
    logic stray;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_cols", 32'(cols_out), 32'h0);
    checkOutput("rst_keys", 32'(keys), 32'h0);
    checkOutput("rst_valid", 32'(event_valid), 32'h0);
    checkOutput("rst_index", 32'(event_index), 32'h0);
    checkOutput("rst_pressed", 32'(event_pressed), 32'h0);
    checkOutput("rst_frame", 32'(frame_done), 32'h0);

    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, '0);
    @(negedge clk);
    checkOutput("first_drive", 32'(cols_out), 32'h01);

    // Asynchronous reset in the middle of DRIVE
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_cols", 32'(cols_out), 32'h0);
    checkOutput("rst_mid_keys", 32'(keys), 32'h0);
    checkOutput("rst_mid_valid", 32'(event_valid), 32'h0);
    checkOutput("rst_mid_frame", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("redrive", 32'(cols_out), 32'h01);

    // Frame timing on an idle matrix
    base = ev_count;
    waitFrame("frame1_seen", n);
    checkOutput("frame1_latency", 32'(n), 32'd29);
    waitFrame("frame2_seen", n);
    checkOutput("frame_period", 32'(n), 32'd30);
    @(negedge clk);
    checkOutput("frame_pulse_width", 32'(frame_done), 32'h0);
    checkOutput("frame_wrap_col0", 32'(cols_out), 32'h01);

    // Bounce: key 13 seen for one column-3 scan only
    applyStimulus(1'b1, 1'b1, 25'(1) << 13);
    waitFrame("bounce_f1", n);
    applyStimulus(1'b1, 1'b1, '0);
    waitFrame("bounce_f2", n);
    checkOutput("bounce_keys", 32'(keys), 32'h0);
    checkOutput("bounce_events", 32'(ev_count - base), 32'd0);

    // Single press of key 13: needs two consecutive column-3 scans
    applyStimulus(1'b1, 1'b1, 25'(1) << 13);
    waitFrame("press_f1", n);
    checkOutput("press_after1", 32'(keys), 32'h0);
    waitFrame("press_f2", n);
    checkOutput("press_after2", 32'(keys), 32'h0000_2000);
    checkOutput("press_events", 32'(ev_count - base), 32'd1);
    checkOutput("press_index", 32'(last_idx), 32'd13);
    checkOutput("press_dir", 32'(last_pressed), 32'd1);

    // Release of key 13
    applyStimulus(1'b1, 1'b1, '0);
    waitFrame("rel_f1", n);
    checkOutput("rel_after1", 32'(keys), 32'h0000_2000);
    checkOutput("rel_events1", 32'(ev_count - base), 32'd1);
    waitFrame("rel_f2", n);
    checkOutput("rel_after2", 32'(keys), 32'h0);
    checkOutput("rel_events2", 32'(ev_count - base), 32'd2);
    checkOutput("rel_index", 32'(last_idx), 32'd13);
    checkOutput("rel_dir", 32'(last_pressed), 32'd0);

    // Same-column pair (keys 1 and 21) with back-pressure
    base = ev_count;
    applyStimulus(1'b1, 1'b0, (25'(1) << 1) | (25'(1) << 21));
    waitValid("pair_valid");
    checkOutput("pair_first_idx", 32'(event_index), 32'd1);
    checkOutput("pair_first_dir", 32'(event_pressed), 32'd1);
    checkOutput("pair_cols", 32'(cols_out), 32'h02);
    checkOutput("pair_keys", 32'(keys), 32'h0020_0002);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(event_valid && event_index == 5'd1 && event_pressed &&
            cols_out == 5'b00010 && !frame_done)) stable = 1'b0;
    end
    checkOutput("pair_hold_stable", 32'(stable), 32'd1);
    checkOutput("pair_no_accept", 32'(ev_count - base), 32'd0);
    event_ready = 1'b1;
    @(negedge clk);
    checkOutput("pair_second_valid", 32'(event_valid), 32'd1);
    checkOutput("pair_second_idx", 32'(event_index), 32'd21);
    checkOutput("pair_second_cols", 32'(cols_out), 32'h02);
    @(negedge clk);
    checkOutput("pair_done_valid", 32'(event_valid), 32'd0);
    checkOutput("pair_break_cols", 32'(cols_out), 32'h0);
    checkOutput("pair_events", 32'(ev_count - base), 32'd2);
    checkOutput("pair_last_idx", 32'(last_idx), 32'd21);

    // Drop ena during column-2 DRIVE: the column completes, then scanning stops
    waitCols("ena_col2_seen", 5'b00100);
    ena = 1'b0;
    n = 0;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (cols_out == '0) break;
      if (cols_out != 5'b00100) stray = 1'b1;
    end
    checkOutput("ena_col2_cycles", 32'(n), 32'd5);
    checkOutput("ena_col2_only", 32'(stray), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cols_out != '0 || frame_done) quiet = 1'b0;
    end
    checkOutput("ena_idle_quiet", 32'(quiet), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    checkOutput("ena_resume_col3", 32'(cols_out), 32'h08);

    // Reset while an event is offered discards it
    applyStimulus(1'b1, 1'b0, '0);
    waitValid("emit_valid");
    checkOutput("emit_idx", 32'(event_index), 32'd1);
    checkOutput("emit_dir", 32'(event_pressed), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("emit_rst_valid", 32'(event_valid), 32'd0);
    checkOutput("emit_rst_cols", 32'(cols_out), 32'h0);
    checkOutput("emit_rst_index", 32'(event_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
